instr_step_sequencer: RTL and testbench

Parametrised control-step generator for the bus datapath. On a `start` pulse it runs the instruction fetch (T0–T2), decodes the IR, and then drives the execute steps for either a three-register ALU op (result to Ra) or a MUL/DIV (result to LO/HI). It replaces hand-sequenced control strobes. Its outputs connect one-for-one to the datapath control inputs. It also adds configurable ALU wait states, a start/busy/done handshake and illegal-register detection.

---
 rtl/instr_step_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_instr_step_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_step_sequencer.sv
// instr_step_sequencer
// Generates the control-step strobes for one instruction on the bus datapath.
// A start pulse in IDLE runs the fetch (T0-T2) and then the execute steps:
//   - a three-register ALU op: Rb -> Y, Rb op Rc -> Z, Z -> Ra
//   - MUL/DIV: the result goes to LO (T5) and HI (T6)
// ALU_WAIT extra cycles can be inserted after T4. An Rb, Rc or Ra index that
// is out of range aborts the instruction in T3 with a one-cycle err pulse.
//
// Ports:
//   Clock, reset (sync, active-low), start  - control inputs
//   IRVal                                   - IR contents; fields decoded live
//   PCout .. HIin                           - single-bit datapath strobes
//   GPRin, GPRout                           - one-hot register enables
//   MUL, DIV, alu_op                        - ALU mode / opcode
//   busy, done, err, step                   - handshake and debug state code
// Every output comes from a register. The registered outputs are decoded from
// the next state, so each step's strobes appear in the cycle of that step.
module instr_step_sequencer #(
    parameter int         BITS      = 32,
    parameter int         REGISTERS = 16,
    parameter int         ALU_WAIT  = 0,
    parameter logic [4:0] OP_MUL    = 5'b01110,
    parameter logic [4:0] OP_DIV    = 5'b01111
) (
    input  logic                 Clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BITS-1:0]      IRVal,
    output logic                 PCout,
    output logic                 MARin,
    output logic                 IncPC,
    output logic                 RZin,
    output logic                 Read,
    output logic                 MDRin,
    output logic                 PCin,
    output logic                 Zlowout,
    output logic                 Zhighout,
    output logic                 MDRout,
    output logic                 IRin,
    output logic                 RYin,
    output logic                 LOin,
    output logic                 HIin,
    output logic [REGISTERS-1:0] GPRin,
    output logic [REGISTERS-1:0] GPRout,
    output logic                 MUL,
    output logic                 DIV,
    output logic [4:0]           alu_op,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [3:0]           step
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_WAIT = 4'd8
    } state_t;

    typedef struct packed {
        logic       pc_out;
        logic       mar_in;
        logic       inc_pc;
        logic       rz_in;
        logic       rd;
        logic       mdr_in;
        logic       pc_in;
        logic       zlow_out;
        logic       zhigh_out;
        logic       mdr_out;
        logic       ir_in;
        logic       ry_in;
        logic       lo_in;
        logic       hi_in;
        logic       mul;
        logic       div;
        logic [4:0] alu_op;
        logic       busy;
        logic       done;
        logic       err;
    } ctl_t;

    state_t                 state_q, state_d;
    logic [3:0]             wait_cnt_q, wait_cnt_d;
    ctl_t                   ctl_q, ctl_d;
    logic [REGISTERS-1:0]   gpr_in_q, gpr_in_d;
    logic [REGISTERS-1:0]   gpr_out_q, gpr_out_d;

    // IR fields, decoded live from IRVal
    logic [4:0] opcode_s;
    logic [3:0] ra_s, rb_s, rc_s;
    logic       is_md_s;
    logic       bad_idx_s;
    logic       ir_unused_s;

    assign opcode_s    = IRVal[BITS-1  -: 5];
    assign ra_s        = IRVal[BITS-6  -: 4];
    assign rb_s        = IRVal[BITS-10 -: 4];
    assign rc_s        = IRVal[BITS-14 -: 4];
    assign ir_unused_s = ^IRVal[BITS-18:0];
    assign is_md_s     = (opcode_s == OP_MUL) || (opcode_s == OP_DIV);
    // Ra is not a destination for MUL/DIV, so it is only range-checked for ALU ops
    assign bad_idx_s   = (int'(rb_s) >= REGISTERS) || (int'(rc_s) >= REGISTERS) ||
                         (!is_md_s && (int'(ra_s) >= REGISTERS));

    function automatic logic [REGISTERS-1:0] onehot_f(input logic [3:0] idx);
        onehot_f = {{(REGISTERS-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Next-state sequencing and decode of the outputs for the step being entered
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ctl_d      = '0;
        gpr_in_d   = '0;
        gpr_out_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_T0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T0: state_d = S_T1;
            S_T1: state_d = S_T2;
            S_T2: state_d = S_T3;
            S_T3: begin
                // The err flag shown in T3 decides the abort, so the pulse and
                // the return to IDLE always agree.
                if (ctl_q.err) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_T4;
                end
            end
            S_T4: begin
                if (ALU_WAIT == 0) begin
                    state_d = S_T5;
                end else begin
                    state_d    = S_WAIT;
                    wait_cnt_d = 4'(ALU_WAIT - 1);
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = S_T5;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_T5: begin
                if (is_md_s) begin
                    state_d = S_T6;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T6:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_T0: begin
                ctl_d.pc_out = 1'b1;
                ctl_d.mar_in = 1'b1;
                ctl_d.inc_pc = 1'b1;
                ctl_d.rz_in  = 1'b1;
                ctl_d.busy   = 1'b1;
            end
            S_T1: begin
                ctl_d.zlow_out = 1'b1;
                ctl_d.pc_in    = 1'b1;
                ctl_d.rd       = 1'b1;
                ctl_d.mdr_in   = 1'b1;
                ctl_d.busy     = 1'b1;
            end
            S_T2: begin
                ctl_d.mdr_out = 1'b1;
                ctl_d.ir_in   = 1'b1;
                ctl_d.busy    = 1'b1;
            end
            S_T3: begin
                ctl_d.busy = 1'b1;
                if (bad_idx_s) begin
                    ctl_d.err = 1'b1;
                end else begin
                    gpr_out_d   = onehot_f(rb_s);
                    ctl_d.ry_in = 1'b1;
                end
            end
            S_T4, S_WAIT: begin
                gpr_out_d    = onehot_f(rc_s);
                ctl_d.rz_in  = 1'b1;
                ctl_d.mul    = (opcode_s == OP_MUL);
                ctl_d.div    = (opcode_s == OP_DIV);
                ctl_d.alu_op = is_md_s ? 5'd0 : opcode_s;
                ctl_d.busy   = 1'b1;
            end
            S_T5: begin
                ctl_d.zlow_out = 1'b1;
                ctl_d.busy     = 1'b1;
                if (is_md_s) begin
                    ctl_d.lo_in = 1'b1;
                end else begin
                    gpr_in_d   = onehot_f(ra_s);
                    ctl_d.done = 1'b1;
                end
            end
            S_T6: begin
                ctl_d.zhigh_out = 1'b1;
                ctl_d.hi_in     = 1'b1;
                ctl_d.done      = 1'b1;
                ctl_d.busy      = 1'b1;
            end
            default: ctl_d = '0;
        endcase
    end

    // State, wait counter and registered outputs, with synchronous active-low reset
    always_ff @(posedge Clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            ctl_q      <= '0;
            gpr_in_q   <= '0;
            gpr_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ctl_q      <= ctl_d;
            gpr_in_q   <= gpr_in_d;
            gpr_out_q  <= gpr_out_d;
        end
    end

    assign PCout    = ctl_q.pc_out;
    assign MARin    = ctl_q.mar_in;
    assign IncPC    = ctl_q.inc_pc;
    assign RZin     = ctl_q.rz_in;
    assign Read     = ctl_q.rd;
    assign MDRin    = ctl_q.mdr_in;
    assign PCin     = ctl_q.pc_in;
    assign Zlowout  = ctl_q.zlow_out;
    assign Zhighout = ctl_q.zhigh_out;
    assign MDRout   = ctl_q.mdr_out;
    assign IRin     = ctl_q.ir_in;
    assign RYin     = ctl_q.ry_in;
    assign LOin     = ctl_q.lo_in;
    assign HIin     = ctl_q.hi_in;
    assign MUL      = ctl_q.mul;
    assign DIV      = ctl_q.div;
    assign alu_op   = ctl_q.alu_op;
    assign busy     = ctl_q.busy;
    assign done     = ctl_q.done;
    assign err      = ctl_q.err;
    assign GPRin    = gpr_in_q;
    assign GPRout   = gpr_out_q;
    assign step     = state_q;

endmodule

// File: tb/tb_instr_step_sequencer.sv
// Testbench for instr_step_sequencer. Three instances are used:
//   u[0]: defaults (16 regs, ALU_WAIT=0)
//   u[1]: ALU_WAIT=3
//   u[2]: REGISTERS=8, ALU_WAIT=1
// The reference model is a cycle timeline built from the instruction's rules
// (fetch, read Rb, ALU for 1+wait cycles, write-back, optional HI step).
// Step codes: IDLE=0, T0..T6=1..7, WAIT=8.
module tb_instr_step_sequencer;

    typedef struct packed {
        logic [13:0] strb;   // PCout,MARin,IncPC,RZin,Read,MDRin,PCin,Zlowout,Zhighout,MDRout,IRin,RYin,LOin,HIin
        logic [15:0] gin;
        logic [15:0] gout;
        logic        mul;
        logic        div;
        logic [4:0]  op;
        logic        busy;
        logic        done;
        logic        err;
        logic [3:0]  step;
    } obs_t;

    typedef struct {
        int          d;
        logic [31:0] ir;
        int          pulse_n;
        int          done_at;
        int          err_at;
        int          opc;
    } vec_t;

    localparam logic [13:0] M_PCOUT  = 14'h2000;
    localparam logic [13:0] M_MARIN  = 14'h1000;
    localparam logic [13:0] M_INCPC  = 14'h0800;
    localparam logic [13:0] M_RZIN   = 14'h0400;
    localparam logic [13:0] M_READ   = 14'h0200;
    localparam logic [13:0] M_MDRIN  = 14'h0100;
    localparam logic [13:0] M_PCIN   = 14'h0080;
    localparam logic [13:0] M_ZLOW   = 14'h0040;
    localparam logic [13:0] M_ZHIGH  = 14'h0020;
    localparam logic [13:0] M_MDROUT = 14'h0010;
    localparam logic [13:0] M_IRIN   = 14'h0008;
    localparam logic [13:0] M_RYIN   = 14'h0004;
    localparam logic [13:0] M_LOIN   = 14'h0002;
    localparam logic [13:0] M_HIIN   = 14'h0001;
    localparam logic [4:0]  OPC_MUL  = 5'b01110;
    localparam logic [4:0]  OPC_DIV  = 5'b01111;

    logic        clk = 1'b0;
    logic        rst_s   [3];
    logic        start_s [3];
    logic [31:0] ir_s    [3];
    obs_t        obs_a   [3];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int NR = (g == 2) ? 8 : 16;
        localparam int NW = (g == 0) ? 0 : ((g == 1) ? 3 : 1);
        logic [13:0]   sb;
        logic [NR-1:0] gin_s, gout_s;
        logic          mu, dv, bz, dn, er;
        logic [4:0]    op;
        logic [3:0]    st;
        instr_step_sequencer #(.BITS(32), .REGISTERS(NR), .ALU_WAIT(NW)) dut (
            .Clock(clk), .reset(rst_s[g]), .start(start_s[g]), .IRVal(ir_s[g]),
            .PCout(sb[13]), .MARin(sb[12]), .IncPC(sb[11]), .RZin(sb[10]),
            .Read(sb[9]), .MDRin(sb[8]), .PCin(sb[7]), .Zlowout(sb[6]),
            .Zhighout(sb[5]), .MDRout(sb[4]), .IRin(sb[3]), .RYin(sb[2]),
            .LOin(sb[1]), .HIin(sb[0]), .GPRin(gin_s), .GPRout(gout_s),
            .MUL(mu), .DIV(dv), .alu_op(op), .busy(bz), .done(dn), .err(er), .step(st)
        );
        assign obs_a[g] = {sb, 16'(gin_s), 16'(gout_s), mu, dv, op, bz, dn, er, st};
    end

    function automatic int nregs_of(input int d);
        return (d == 2) ? 8 : 16;
    endfunction

    function automatic int nwait_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 1);
    endfunction

    function automatic bit is_md(input logic [31:0] ir);
        return (ir[31:27] == OPC_MUL) || (ir[31:27] == OPC_DIV);
    endfunction

    function automatic bit is_bad(input int d, input logic [31:0] ir);
        int nr;
        nr = nregs_of(d);
        return (int'(ir[22:19]) >= nr) || (int'(ir[18:15]) >= nr) ||
               (!is_md(ir) && (int'(ir[26:23]) >= nr));
    endfunction

    // Index (cycles after T0) of the final active cycle of the instruction
    function automatic int last_of(input int d, input logic [31:0] ir);
        if (is_bad(d, ir)) return 3;
        return (is_md(ir) ? 6 : 5) + nwait_of(d);
    endfunction

    // Expected outputs n cycles after entering T0
    function automatic obs_t expect_at(input int d, input logic [31:0] ir, input int n);
        obs_t        e;
        int          nw;
        bit          md, bad;
        logic [4:0]  opc;
        e   = '0;
        nw  = nwait_of(d);
        md  = is_md(ir);
        bad = is_bad(d, ir);
        opc = ir[31:27];
        if (n == 0) begin
            e.strb = M_PCOUT | M_MARIN | M_INCPC | M_RZIN; e.busy = 1'b1; e.step = 4'd1;
        end else if (n == 1) begin
            e.strb = M_ZLOW | M_PCIN | M_READ | M_MDRIN; e.busy = 1'b1; e.step = 4'd2;
        end else if (n == 2) begin
            e.strb = M_MDROUT | M_IRIN; e.busy = 1'b1; e.step = 4'd3;
        end else if (n == 3) begin
            e.busy = 1'b1; e.step = 4'd4;
            if (bad) begin
                e.err = 1'b1;
            end else begin
                e.gout = 16'd1 << ir[22:19];
                e.strb = M_RYIN;
            end
        end else if (!bad && n >= 4 && n <= 4 + nw) begin
            e.busy = 1'b1;
            e.step = (n == 4) ? 4'd5 : 4'd8;
            e.gout = 16'd1 << ir[18:15];
            e.strb = M_RZIN;
            if (opc == OPC_MUL)      e.mul = 1'b1;
            else if (opc == OPC_DIV) e.div = 1'b1;
            else                     e.op  = opc;
        end else if (!bad && n == 5 + nw) begin
            e.busy = 1'b1; e.step = 4'd6;
            if (md) begin
                e.strb = M_ZLOW | M_LOIN;
            end else begin
                e.strb = M_ZLOW;
                e.gin  = 16'd1 << ir[26:23];
                e.done = 1'b1;
            end
        end else if (!bad && md && n == 6 + nw) begin
            e.strb = M_ZHIGH | M_HIIN; e.busy = 1'b1; e.done = 1'b1; e.step = 4'd7;
        end
        return e;
    endfunction

    task automatic check_obs(input string nm, input obs_t got, input obs_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    // Runs one instruction from IDLE; called right after a negedge sample.
    task automatic run_instr(input int d, input logic [31:0] ir, input bit rnd, input int pulse_n,
                             output int done_at, output int err_at, output int opc, output int dcnt);
        int   last;
        obs_t got;
        last    = last_of(d, ir);
        done_at = 0; err_at = 0; opc = 0; dcnt = 0;
        ir_s[d]    = ir;
        start_s[d] = 1'b1;
        for (int n = 0; n <= last + 2; n++) begin
            @(negedge clk);
            got = obs_a[d];
            check_obs($sformatf("u%0d ir=%h cyc%0d", d, ir, n), got, expect_at(d, ir, n));
            if (got.done) begin
                dcnt++;
                if (done_at == 0) done_at = n + 1;
            end
            if (got.err && err_at == 0) err_at = n + 1;
            if (got.mul || got.div || got.op != 5'd0) opc++;
            if (rnd) start_s[d] = (n < last) ? 1'($urandom_range(0, 1)) : 1'b0;
            else     start_s[d] = (n == pulse_n);
        end
    endtask

    vec_t tbl [9];
    int   da, ea, oc, dc;

    initial begin
        tbl[0] = '{d: 0, ir: 32'h70120000, pulse_n: -1, done_at: 7,  err_at: 0, opc: 1};
        tbl[1] = '{d: 0, ir: 32'h1A920000, pulse_n: -1, done_at: 6,  err_at: 0, opc: 1};
        tbl[2] = '{d: 1, ir: 32'h78120000, pulse_n: -1, done_at: 10, err_at: 0, opc: 4};
        tbl[3] = '{d: 2, ir: 32'h70160000, pulse_n: -1, done_at: 0,  err_at: 4, opc: 0};
        tbl[4] = '{d: 1, ir: 32'h1A920000, pulse_n: -1, done_at: 9,  err_at: 0, opc: 4};
        tbl[5] = '{d: 2, ir: 32'h1A920000, pulse_n: -1, done_at: 7,  err_at: 0, opc: 2};
        tbl[6] = '{d: 2, ir: 32'h1C920000, pulse_n: -1, done_at: 0,  err_at: 4, opc: 0};
        tbl[7] = '{d: 2, ir: 32'h74920000, pulse_n: 2,  done_at: 8,  err_at: 0, opc: 2};
        tbl[8] = '{d: 0, ir: 32'h70120000, pulse_n: 2,  done_at: 7,  err_at: 0, opc: 1};

        // reset with start high: everything stays at zero
        for (int i = 0; i < 3; i++) begin
            rst_s[i] = 1'b0; start_s[i] = 1'b1; ir_s[i] = 32'h70120000;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_obs($sformatf("reset u%0d", i), obs_a[i], '0);
        for (int i = 0; i < 3; i++) begin
            rst_s[i] = 1'b1; start_s[i] = 1'b0;
        end

        // directed table
        for (int i = 0; i < 9; i++) begin
            run_instr(tbl[i].d, tbl[i].ir, 1'b0, tbl[i].pulse_n, da, ea, oc, dc);
            check_int($sformatf("vec%0d done_at", i), da, tbl[i].done_at);
            check_int($sformatf("vec%0d err_at", i), ea, tbl[i].err_at);
            check_int($sformatf("vec%0d op_cycles", i), oc, tbl[i].opc);
            check_int($sformatf("vec%0d done_count", i), dc, (tbl[i].done_at != 0) ? 1 : 0);
        end

        // reset during T4 of a MUL, then a full instruction
        ir_s[0] = 32'h70120000; start_s[0] = 1'b1;
        for (int n = 0; n <= 4; n++) begin
            @(negedge clk);
            check_obs($sformatf("pre-rst u0 cyc%0d", n), obs_a[0], expect_at(0, ir_s[0], n));
            start_s[0] = 1'b0;
        end
        rst_s[0] = 1'b0;
        @(negedge clk);
        check_obs("rst in T4", obs_a[0], '0);
        rst_s[0] = 1'b1;
        run_instr(0, 32'h70120000, 1'b0, -1, da, ea, oc, dc);
        check_int("after rst done_at", da, 7);

        // reset during WAIT of a DIV, then a full instruction with all 4 op cycles
        ir_s[1] = 32'h78120000; start_s[1] = 1'b1;
        for (int n = 0; n <= 5; n++) begin
            @(negedge clk);
            check_obs($sformatf("pre-rst u1 cyc%0d", n), obs_a[1], expect_at(1, ir_s[1], n));
            start_s[1] = 1'b0;
        end
        rst_s[1] = 1'b0;
        @(negedge clk);
        check_obs("rst in WAIT", obs_a[1], '0);
        rst_s[1] = 1'b1;
        run_instr(1, 32'h78120000, 1'b0, -1, da, ea, oc, dc);
        check_int("after wait-rst done_at", da, 10);
        check_int("after wait-rst op_cycles", oc, 4);

        // back-to-back ADDs with start held high: one IDLE cycle between them
        ir_s[0] = 32'h1A920000; start_s[0] = 1'b1;
        for (int n = 0; n <= 13; n++) begin
            obs_t e;
            @(negedge clk);
            if (n <= 5)       e = expect_at(0, ir_s[0], n);
            else if (n == 6)  e = '0;
            else if (n <= 12) e = expect_at(0, ir_s[0], n - 7);
            else              e = '0;
            check_obs($sformatf("b2b cyc%0d", n), obs_a[0], e);
            if (n == 7) start_s[0] = 1'b0;
        end

        // random instructions with stray start pulses while busy
        for (int k = 0; k < 120; k++) begin
            int          d, sel, gap;
            logic [4:0]  opc;
            logic [31:0] ir;
            d   = $urandom_range(0, 2);
            sel = $urandom_range(0, 3);
            opc = (sel == 0) ? OPC_MUL : ((sel == 1) ? OPC_DIV : 5'($urandom_range(0, 31)));
            ir  = {opc, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 15'($urandom)};
            run_instr(d, ir, 1'b1, -1, da, ea, oc, dc);
            check_int($sformatf("rnd%0d done_count", k), dc, is_bad(d, ir) ? 0 : 1);
            gap = $urandom_range(0, 2);
            for (int j = 0; j < gap; j++) begin
                @(negedge clk);
                check_obs($sformatf("rnd%0d idle", k), obs_a[d], '0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
